// File: rtl/uart_rx_fifo.sv
// 8N1 serial receiver with a programmable bit period, feeding a first-word-fall-through
// byte FIFO. Framing and overrun errors are reported through sticky flags.
module uart_rx_fifo #(
    parameter int DEPTH = 16,
    parameter int DIV_W = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     rxd,
    input  logic [DIV_W-1:0]         baud_div,
    input  logic                     rd_en,
    input  logic                     clr_err,
    output logic [7:0]               rd_data,
    output logic                     rx_valid,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     frame_err,
    output logic                     overrun,
    output logic                     busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    // ---------------------------------------------------------------- receiver
    logic             meta_reg;
    logic             rxs;
    state_t           state_reg, state_next;
    logic [DIV_W-1:0] timer_reg, timer_next;
    logic [DIV_W-1:0] div_reg, div_next;
    logic [2:0]       bit_idx_reg, bit_idx_next;
    logic [7:0]       shift_reg, shift_next;
    logic             push;
    logic             frame_set;
    logic             timer_zero;

    assign timer_zero = (timer_reg == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_reg    <= 1'b1;
            rxs         <= 1'b1;
            state_reg   <= S_IDLE;
            timer_reg   <= '0;
            div_reg     <= '0;
            bit_idx_reg <= '0;
            shift_reg   <= '0;
        end else begin
            meta_reg    <= rxd;
            rxs         <= meta_reg;
            state_reg   <= state_next;
            timer_reg   <= timer_next;
            div_reg     <= div_next;
            bit_idx_reg <= bit_idx_next;
            shift_reg   <= shift_next;
        end
    end

    // IDLE is only ever entered with rxs high, so a low level there is the start edge.
    always_comb begin
        state_next   = state_reg;
        timer_next   = timer_reg;
        div_next     = div_reg;
        bit_idx_next = bit_idx_reg;
        shift_next   = shift_reg;
        push         = 1'b0;
        frame_set    = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (!rxs) begin
                    div_next   = baud_div;
                    timer_next = baud_div >> 1;
                    state_next = S_START;
                end
            end
            S_START: begin
                if (!timer_zero) begin
                    timer_next = timer_reg - DIV_W'(1);
                end else if (!rxs) begin
                    timer_next   = div_reg;
                    bit_idx_next = '0;
                    state_next   = S_DATA;
                end else begin
                    state_next = S_IDLE;
                end
            end
            S_DATA: begin
                if (!timer_zero) begin
                    timer_next = timer_reg - DIV_W'(1);
                end else begin
                    shift_next   = {rxs, shift_reg[7:1]};
                    timer_next   = div_reg;
                    bit_idx_next = bit_idx_reg + 3'd1;
                    if (bit_idx_reg == 3'd7) begin
                        state_next = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (!timer_zero) begin
                    timer_next = timer_reg - DIV_W'(1);
                end else if (rxs) begin
                    push       = 1'b1;
                    state_next = S_IDLE;
                end else begin
                    frame_set  = 1'b1;
                    state_next = S_BREAK;
                end
            end
            S_BREAK: begin
                if (rxs) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign busy = (state_reg != S_IDLE);

    // -------------------------------------------------------------------- FIFO
    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [PW-1:0] wr_ptr_next, rd_ptr_next;
    logic          empty;
    logic          full;
    logic          pop_ok;
    logic          push_ok;
    logic          ovr_set;

    assign empty       = (wr_ptr_reg == rd_ptr_reg);
    assign full        = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                         (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign pop_ok      = rd_en && !empty;
    assign push_ok     = push && (!full || pop_ok);
    assign ovr_set     = push && full && !pop_ok;
    assign rd_ptr_next = rd_ptr_reg + PW'(pop_ok);
    assign wr_ptr_next = wr_ptr_reg + PW'(push_ok);

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg[AW-1:0]] <= shift_reg;
        end
    end

    // rd_data is the registered head; bypass the incoming byte when it becomes the head.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            rd_data    <= 8'h00;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            if (push_ok || pop_ok) begin
                if (push_ok && (rd_ptr_next == wr_ptr_reg)) begin
                    rd_data <= shift_reg;
                end else begin
                    rd_data <= mem[rd_ptr_next[AW-1:0]];
                end
            end
            if (frame_set) begin
                frame_err <= 1'b1;
            end else if (clr_err) begin
                frame_err <= 1'b0;
            end
            if (ovr_set) begin
                overrun <= 1'b1;
            end else if (clr_err) begin
                overrun <= 1'b0;
            end
        end
    end

    assign count    = wr_ptr_reg - rd_ptr_reg;
    assign rx_valid = !empty;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: drives 8N1 frames at baud_div=9 (10 clocks per bit)
// and checks FIFO contents, flags and timing against hand-computed values.
module tb_uart_rx_fifo;

    logic        clk;
    logic        reset;
    logic        rxd;
    logic [15:0] baud_div;
    logic        rd_en;
    logic        clr_err;
    logic [7:0]  rd_data;
    logic        rx_valid;
    logic [4:0]  count;
    logic        frame_err;
    logic        overrun;
    logic        busy;

    int n_cmp;
    int n_mis;

    uart_rx_fifo #(.DEPTH(16), .DIV_W(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .rxd       (rxd),
        .baud_div  (baud_div),
        .rd_en     (rd_en),
        .clr_err   (clr_err),
        .rd_data   (rd_data),
        .rx_valid  (rx_valid),
        .count     (count),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges, then settle 1 ns so inputs change and outputs are sampled off-edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Start bit plus 8 data bits; returns 1 ns after the edge that ends the last data bit.
    task automatic send_head(input logic [7:0] b);
        rxd = 1'b0;
        tick(10);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            tick(10);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_head(b);
        rxd = 1'b1;
        tick(10);
    endtask

    task automatic pop;
        rd_en = 1'b1;
        tick(1);
        rd_en = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick(3);
        n_cmp++; if (rd_data !== 8'h00) begin n_mis++; $display("FAIL reset_rd_data: got %h expected 00", rd_data); end
        n_cmp++; if (rx_valid !== 1'b0) begin n_mis++; $display("FAIL reset_rx_valid: got %b expected 0", rx_valid); end
        n_cmp++; if (count !== 5'd0) begin n_mis++; $display("FAIL reset_count: got %0d expected 0", count); end
        n_cmp++; if (frame_err !== 1'b0) begin n_mis++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
        n_cmp++; if (overrun !== 1'b0) begin n_mis++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
        n_cmp++; if (busy !== 1'b0) begin n_mis++; $display("FAIL reset_busy: got %b expected 0", busy); end
        reset = 1'b0;
        tick(3);
        $display("reset: done");
    endtask

    // Stop sample lands on edge 98 counted from the start-bit drive.
    task automatic test_byte;
        send_head(8'hA5);
        n_cmp++; if (busy !== 1'b1) begin n_mis++; $display("FAIL byte_busy: got %b expected 1", busy); end
        rxd = 1'b1;
        tick(7);
        n_cmp++; if (count !== 5'd0) begin n_mis++; $display("FAIL byte_pre_stop_count: got %0d expected 0", count); end
        tick(1);
        n_cmp++; if (count !== 5'd1) begin n_mis++; $display("FAIL byte_count: got %0d expected 1", count); end
        n_cmp++; if (rx_valid !== 1'b1) begin n_mis++; $display("FAIL byte_rx_valid: got %b expected 1", rx_valid); end
        n_cmp++; if (rd_data !== 8'hA5) begin n_mis++; $display("FAIL byte_rd_data: got %h expected a5", rd_data); end
        n_cmp++; if (busy !== 1'b0) begin n_mis++; $display("FAIL byte_idle: got %b expected 0", busy); end
        n_cmp++; if ({frame_err, overrun} !== 2'b00) begin n_mis++; $display("FAIL byte_flags: got %b expected 00", {frame_err, overrun}); end
        $display("byte: received %h", rd_data);
        tick(2);
        pop();
        n_cmp++; if (count !== 5'd0) begin n_mis++; $display("FAIL byte_pop_count: got %0d expected 0", count); end
        n_cmp++; if (rx_valid !== 1'b0) begin n_mis++; $display("FAIL byte_pop_valid: got %b expected 0", rx_valid); end
    endtask

    task automatic test_frame_err;
        send_head(8'h3C);
        rxd = 1'b0;
        tick(8);
        n_cmp++; if (frame_err !== 1'b1) begin n_mis++; $display("FAIL ferr_set: got %b expected 1", frame_err); end
        n_cmp++; if (count !== 5'd0) begin n_mis++; $display("FAIL ferr_no_push: got %0d expected 0", count); end
        n_cmp++; if (busy !== 1'b1) begin n_mis++; $display("FAIL ferr_break_busy: got %b expected 1", busy); end
        tick(22);
        rxd = 1'b1;
        tick(1);
        n_cmp++; if (busy !== 1'b1) begin n_mis++; $display("FAIL ferr_still_break: got %b expected 1", busy); end
        tick(5);
        n_cmp++; if (busy !== 1'b0) begin n_mis++; $display("FAIL ferr_back_idle: got %b expected 0", busy); end
        send_byte(8'h5A);
        tick(1);
        n_cmp++; if (rd_data !== 8'h5A) begin n_mis++; $display("FAIL ferr_next_data: got %h expected 5a", rd_data); end
        n_cmp++; if (count !== 5'd1) begin n_mis++; $display("FAIL ferr_next_count: got %0d expected 1", count); end
        n_cmp++; if (frame_err !== 1'b1) begin n_mis++; $display("FAIL ferr_sticky: got %b expected 1", frame_err); end
        $display("frame_err: received %h after break", rd_data);
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
        n_cmp++; if (frame_err !== 1'b0) begin n_mis++; $display("FAIL ferr_clear: got %b expected 0", frame_err); end
        pop();
    endtask

    task automatic test_glitch;
        rxd = 1'b0;
        tick(3);
        rxd = 1'b1;
        n_cmp++; if (busy !== 1'b1) begin n_mis++; $display("FAIL glitch_start: got %b expected 1", busy); end
        tick(10);
        n_cmp++; if (busy !== 1'b0) begin n_mis++; $display("FAIL glitch_idle: got %b expected 0", busy); end
        n_cmp++; if (count !== 5'd0) begin n_mis++; $display("FAIL glitch_count: got %0d expected 0", count); end
        n_cmp++; if ({frame_err, overrun} !== 2'b00) begin n_mis++; $display("FAIL glitch_flags: got %b expected 00", {frame_err, overrun}); end
        $display("glitch: rejected");
    endtask

    task automatic test_overrun;
        for (int i = 0; i <= 16; i++) begin
            send_byte(8'(i));
        end
        tick(2);
        n_cmp++; if (count !== 5'd16) begin n_mis++; $display("FAIL ovr_count: got %0d expected 16", count); end
        n_cmp++; if (overrun !== 1'b1) begin n_mis++; $display("FAIL ovr_flag: got %b expected 1", overrun); end
        for (int i = 0; i < 16; i++) begin
            n_cmp++; if (rd_data !== 8'(i)) begin n_mis++; $display("FAIL ovr_drain_%0d: got %h expected %h", i, rd_data, 8'(i)); end
            $display("overrun: drained %h", rd_data);
            pop();
        end
        n_cmp++; if (rx_valid !== 1'b0) begin n_mis++; $display("FAIL ovr_lost_byte: got %b expected 0", rx_valid); end
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
        n_cmp++; if (overrun !== 1'b0) begin n_mis++; $display("FAIL ovr_clear: got %b expected 0", overrun); end
    endtask

    task automatic test_full_pop;
        logic [7:0] exp_q[$];
        for (int i = 0; i < 16; i++) begin
            send_byte(8'h20 + 8'(i));
        end
        n_cmp++; if (count !== 5'd16) begin n_mis++; $display("FAIL full_fill: got %0d expected 16", count); end
        send_head(8'hEE);
        rxd = 1'b1;
        tick(7);
        rd_en = 1'b1;
        tick(1);
        rd_en = 1'b0;
        n_cmp++; if (count !== 5'd16) begin n_mis++; $display("FAIL full_count: got %0d expected 16", count); end
        n_cmp++; if (overrun !== 1'b0) begin n_mis++; $display("FAIL full_overrun: got %b expected 0", overrun); end
        tick(2);
        for (int i = 1; i < 16; i++) exp_q.push_back(8'h20 + 8'(i));
        exp_q.push_back(8'hEE);
        for (int i = 0; i < 16; i++) begin
            n_cmp++; if (rd_data !== exp_q[i]) begin n_mis++; $display("FAIL full_drain_%0d: got %h expected %h", i, rd_data, exp_q[i]); end
            $display("full_pop: drained %h", rd_data);
            pop();
        end
        n_cmp++; if (count !== 5'd0) begin n_mis++; $display("FAIL full_empty: got %0d expected 0", count); end
    endtask

    task automatic test_reset_mid;
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        n_cmp++; if (count !== 5'd3) begin n_mis++; $display("FAIL rmid_queued: got %0d expected 3", count); end
        // 8'h77 = bits 1,1,1,0,1,...; stop partway through bit 4
        rxd = 1'b0; tick(10);
        rxd = 1'b1; tick(30);
        rxd = 1'b0; tick(10);
        rxd = 1'b1; tick(3);
        n_cmp++; if (busy !== 1'b1) begin n_mis++; $display("FAIL rmid_busy: got %b expected 1", busy); end
        reset = 1'b1;
        #1;
        n_cmp++; if (count !== 5'd0) begin n_mis++; $display("FAIL rmid_count: got %0d expected 0", count); end
        n_cmp++; if (rx_valid !== 1'b0) begin n_mis++; $display("FAIL rmid_valid: got %b expected 0", rx_valid); end
        n_cmp++; if (rd_data !== 8'h00) begin n_mis++; $display("FAIL rmid_rd_data: got %h expected 00", rd_data); end
        n_cmp++; if (busy !== 1'b0) begin n_mis++; $display("FAIL rmid_idle: got %b expected 0", busy); end
        tick(2);
        reset = 1'b0;
        tick(3);
        send_byte(8'h81);
        tick(1);
        n_cmp++; if (count !== 5'd1) begin n_mis++; $display("FAIL rmid_new_count: got %0d expected 1", count); end
        n_cmp++; if (rd_data !== 8'h81) begin n_mis++; $display("FAIL rmid_new_data: got %h expected 81", rd_data); end
        $display("reset_mid: received %h", rd_data);
        pop();
        n_cmp++; if (count !== 5'd0) begin n_mis++; $display("FAIL rmid_pop: got %0d expected 0", count); end
    endtask

    initial begin
        n_cmp    = 0;
        n_mis    = 0;
        reset    = 1'b1;
        rxd      = 1'b1;
        baud_div = 16'd9;
        rd_en    = 1'b0;
        clr_err  = 1'b0;
        test_reset();
        test_byte();
        test_frame_err();
        test_glitch();
        test_overrun();
        test_full_pop();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
